// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte/half/word stores, extended loads and
// a fixed access latency that stalls the PC. Optional macro: MISALIGN_TRAP_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRW,
  input  logic        mem_wr,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_type;
  logic          r_is_store;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_in_idle;
  logic          w_commit;
  logic [AW+1:0] w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [2:0]    w_acc_type;
  logic          w_acc_store;
  logic [AW-1:0] w_idx;
  logic          w_half;
  logic          w_word;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic [31:0]   w_rd_word;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_rd_half;
  logic [31:0]   w_load;
  logic          w_unused;

  assign w_unused  = &{1'b0, addr[31:AW+2]};
  assign w_req     = MemRW | mem_wr;
  assign w_in_idle = (r_state == S_IDLE);

  // With zero latency the commit happens straight from IDLE, so the live
  // inputs stand in for the not-yet-latched request.
  assign w_acc_addr  = w_in_idle ? addr[AW+1:0] : r_addr;
  assign w_acc_wdata = w_in_idle ? wdata : r_wdata;
  assign w_acc_store = w_in_idle ? mem_wr : r_is_store;
  assign w_acc_type  = w_in_idle ? (mem_wr ? store_type : load_type) : r_type;
  assign w_idx       = w_acc_addr[AW+1:2];

  assign w_half = w_acc_store ? (w_acc_type == 3'b001) : (w_acc_type[1:0] == 2'b01);
  assign w_word = (w_acc_type == 3'b010);
`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (w_half & w_acc_addr[0]) | (w_word & (w_acc_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) begin
          if (LATENCY == 0) begin
            w_state_next = S_RESP;
            w_commit     = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (r_cnt == 3'd0) begin
          w_state_next = S_RESP;
          w_commit     = 1'b1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wword = w_acc_wdata;
    if (w_acc_store && !w_misalign) begin
      case (w_acc_type)
        3'b000: begin
          w_be    = 4'b0001 << w_acc_addr[1:0];
          w_wword = {4{w_acc_wdata[7:0]}};
        end
        3'b001: begin
          w_be    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
          w_wword = {2{w_acc_wdata[15:0]}};
        end
        3'b010:  w_be = 4'b1111;
        default: w_be = 4'b0000;
      endcase
    end
  end

  assign w_rd_word = r_mem[w_idx];
  assign w_rd_byte = w_rd_word[{w_acc_addr[1:0], 3'b000} +: 8];
  assign w_rd_half = w_acc_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load = 32'd0;
    if (!w_acc_store && !w_misalign) begin
      case (w_acc_type)
        3'b000:  w_load = {{24{w_rd_byte[7]}}, w_rd_byte};
        3'b001:  w_load = {{16{w_rd_half[15]}}, w_rd_half};
        3'b010:  w_load = w_rd_word;
        3'b100:  w_load = {24'd0, w_rd_byte};
        3'b101:  w_load = {16'd0, w_rd_half};
        default: w_load = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_in_idle && w_req) begin
        r_cnt <= CNT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_commit) begin
        r_rdata <= w_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_idle && w_req) begin
      r_addr     <= addr[AW+1:0];
      r_wdata    <= wdata;
      r_is_store <= mem_wr;
      r_type     <= mem_wr ? store_type : load_type;
    end
  end

  // RAM is never reset; a reset on the commit edge discards the store.
  always_ff @(posedge clk) begin
    if (w_commit && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_commit) begin
      r_err <= w_misalign;
    end
  end
  assign err = r_err & (r_state == S_RESP);
`else
  assign err = 1'b0;
`endif

  assign rdata       = r_rdata;
  assign done        = (r_state == S_RESP);
  assign o_dbg_state = r_state;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder serving the load/store requests issued by the processor control logic (MemRW, mem_wr, load_type, store_type).
- Holds a word-organised data RAM and performs byte, halfword and word stores.
- Returns sign- or zero-extended load data.
- Models a fixed access latency, and asserts stall to freeze the PC until the access completes.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the RAM (power of 2)
LATENCY, 2, wait cycles between request acceptance and response (0..7)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
addr  input  32  byte address of the access (ALU result)
wdata  input  32  store data (rs2)
MemRW  input  1  load request
mem_wr  input  1  store request
load_type  input  3  funct3 of load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
store_type  input  3  funct3 of store: 000 SB, 001 SH, 010 SW
rdata  output  32  extended load result, valid while done=1, held until next done
stall  output  1  processor must hold PC and architectural state
done  output  1  one-cycle pulse: access completed this cycle
err  output  1  misaligned-access flag (only with MISALIGN_TRAP_EN, else tied 0)

Behaviour:
- Reset (rst=1 at an edge, has priority over everything):
  - state=IDLE; rdata=0, done=0, err=0, wait counter=0.
  - RAM contents are not reset.
  - Reset mid-access aborts it; an uncommitted store is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is MemRW=1 or mem_wr=1. If both are high, the store wins and the load is ignored.
  - On a request, latch addr, wdata, type and kind. Go to WAIT (counter=LATENCY-1), or to RESP if LATENCY=0.
  - stall = request present (combinational); done=0.
- WAIT:
  - stall=1; the counter decrements each cycle.
  - Go to RESP on the edge where the counter is 0.
  - Inputs are ignored; only latched values are used.
- Commit edge (the edge that enters RESP):
  - Store bytes are written to the RAM.
  - Load data is read, extended and registered into rdata.
- RESP:
  - stall=0, done=1 for exactly one cycle; unconditionally return to IDLE.
  - Requests visible in RESP belong to the completed instruction and are ignored.
- Latency: request first seen in IDLE at cycle 0 gives done=1 at cycle LATENCY+1. Back-to-back accesses therefore take LATENCY+2 cycles each.
- Addressing:
  - word index = addr[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so the address space wraps modulo DEPTH_WORDS*4.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
- Stores:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes the half at addr[1] with wdata[15:0].
  - SW writes all 4 bytes.
  - Any other store_type: no write, still completes with done.
- Loads:
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the word.
  - Any other load_type returns rdata=0.
- Alignment without the feature: addr[0] is ignored for halfwords and addr[1:0] for words (forced alignment), err=0.
- Store-only accesses update rdata to 0 at commit.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - It completes with normal latency; the store is suppressed, rdata=0, and err=1 coincident with done (one cycle).
- Undefined: forced-alignment behaviour as above; err tied to 0.

Test Plan:
1. LATENCY=2: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 → each access gives stall for cycles 0-2, done at cycle 3; rdata=0xDEADBEEF.
2. After test 1, SB addr=0x11 wdata=0x80 → LB 0x11 = 0xFFFFFF80, LBU 0x11 = 0x00000080, LW 0x10 = 0xDEAD80EF.
3. SH addr=0x22 wdata=0x00009ABC → LH 0x22 = 0xFFFF9ABC, LHU 0x22 = 0x00009ABC, LW 0x20 has upper half 0x9ABC and lower half unchanged.
4. MemRW=1 and mem_wr=1 together at addr 0x30 → store performed, single done pulse, rdata=0. Address 0x30+DEPTH_WORDS*4 aliases to the same word.
5. Store to 0x40 with rst asserted during WAIT → state IDLE next cycle, no done, word at 0x40 unchanged.
6. With MISALIGN_TRAP_EN: LW addr=0x13 → done and err both 1 at cycle 3, rdata=0. SH addr=0x41 → err=1 and no write. Without the macro: LW 0x13 returns the word at 0x10 and err=0.
